scan_decoder: RTL and testbench

Parametrised registered binary-to-one-hot decoder with an auto-scan mode. It generalises the combinational 4-to-16 line decoder to SEL_W select bits and a registered output. It adds a direct-load mode and a self-stepping scan mode with programmable dwell and a wrap pulse. It sits between control logic and multiplexed outputs such as digit/row strobes and chip-selects, which need either a fixed line or a rotating line.

---
 rtl/scan_decoder_pkg.sv | 13 +
 rtl/scan_dwell_timer.sv | 31 +++
 rtl/scan_decoder.sv | 109 ++++++++++
 tb/tb_scan_decoder.sv | 129 ++++++++++++
 4 files changed

// File: rtl/scan_decoder_pkg.sv
// Shared mode constants and FSM state encoding for scan_decoder.
package scan_decoder_pkg;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DIRECT = 2'd1,
      ST_SCAN   = 2'd2
   } state_t;

endpackage

// File: rtl/scan_dwell_timer.sv
// Dwell counter for scan_decoder: counts 0..DWELL-1 while run is high,
// flags the terminal count and restarts on clear.
module scan_dwell_timer #(
   parameter int unsigned DWELL = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic run,
   output logic expire
);

   localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

   logic [CW-1:0] cnt;

   // Ungated terminal count; the owner qualifies it with its own run term
   // so the run/expire pair never forms a combinational loop.
   assign expire = (cnt == LAST);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt <= '0;
      end else if (run) begin
         if (expire) cnt <= '0;
         else        cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/scan_decoder.sv
// Registered binary-to-one-hot decoder with direct-load and auto-scan modes.
// Define SCAN_DECODER_ACTIVE_LOW_EN for active-low (one-cold) line output.
module scan_decoder
   import scan_decoder_pkg::*;
#(
   parameter int unsigned SEL_W = 4,
   parameter int unsigned DWELL = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  mode,
   input  logic                  load,
   input  logic [SEL_W-1:0]      sel,
   output logic [(1<<SEL_W)-1:0] line,
   output logic [SEL_W-1:0]      idx,
   output logic                  wrap
);

   localparam int unsigned OUT_W = 1 << SEL_W;

`ifdef SCAN_DECODER_ACTIVE_LOW_EN
   localparam logic [OUT_W-1:0] LINE_OFF = '1;
`else
   localparam logic [OUT_W-1:0] LINE_OFF = '0;
`endif

   state_t             state, state_d;
   logic [SEL_W-1:0]   idx_d;
   logic               wrap_d;
   logic [OUT_W-1:0]   hot;
   logic [OUT_W-1:0]   line_d;
   logic               clr;
   logic               run;
   logic               expire;

   scan_dwell_timer #(.DWELL(DWELL)) u_timer (
      .clk    (clk),
      .rst    (rst),
      .clear  (clr),
      .run    (run),
      .expire (expire)
   );

   always_comb begin
      state_d = state;
      idx_d   = idx;
      wrap_d  = 1'b0;
      clr     = 1'b0;
      run     = 1'b0;
      if (!en) begin
         state_d = ST_IDLE;
      end else if (load) begin
         idx_d   = sel;
         clr     = 1'b1;
         state_d = (mode == MODE_SCAN) ? ST_SCAN : ST_DIRECT;
      end else begin
         case (state)
            ST_DIRECT: begin
               if (mode == MODE_SCAN) begin
                  state_d = ST_SCAN;
                  clr     = 1'b1;
               end
            end
            ST_SCAN: begin
               if (mode == MODE_DIRECT) begin
                  state_d = ST_DIRECT;
               end else begin
                  run = 1'b1;
                  if (expire) begin
                     idx_d  = idx + SEL_W'(1);
                     wrap_d = &idx;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      hot        = '0;
      hot[idx_d] = 1'b1;
      if (state_d == ST_IDLE) begin
         line_d = LINE_OFF;
      end else begin
`ifdef SCAN_DECODER_ACTIVE_LOW_EN
         line_d = ~hot;
`else
         line_d = hot;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         idx   <= '0;
         wrap  <= 1'b0;
         line  <= LINE_OFF;
      end else begin
         state <= state_d;
         idx   <= idx_d;
         wrap  <= wrap_d;
         line  <= line_d;
      end
   end

endmodule

// File: tb/tb_scan_decoder.sv
// Directed self-checking bench for scan_decoder (SEL_W=4, DWELL=4) using an
// expectation queue that is filled at drive time and drained after each edge.
module tb_scan_decoder;

   typedef struct packed {
      logic [15:0] line;
      logic [3:0]  idx;
      logic        wrap;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en = 1'b0;
   logic        mode = 1'b0;
   logic        load = 1'b0;
   logic [3:0]  sel = '0;
   logic [15:0] line;
   logic [3:0]  idx;
   logic        wrap;

   int unsigned n_assert = 0;
   int unsigned n_fail   = 0;
   exp_t        sb[$];

   scan_decoder #(.SEL_W(4), .DWELL(4)) dut (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .mode (mode),
      .load (load),
      .sel  (sel),
      .line (line),
      .idx  (idx),
      .wrap (wrap)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] mk_line(input logic on, input logic [3:0] i);
      logic [15:0] v;
      v = on ? (16'h0001 << i) : 16'h0000;
`ifdef SCAN_DECODER_ACTIVE_LOW_EN
      v = ~v;
`endif
      return v;
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, queue the expected post-edge outputs, compare.
   task automatic cyc(input string tag, input logic r, input logic e, input logic m,
                      input logic l, input logic [3:0] s,
                      input logic on, input logic [3:0] ei, input logic ew);
      exp_t x;
      @(negedge clk);
      rst = r; en = e; mode = m; load = l; sel = s;
      sb.push_back('{line: mk_line(on, ei), idx: ei, wrap: ew});
      @(posedge clk);
      #1;
      x = sb.pop_front();
      check({tag, ".line"}, line, x.line);
      check({tag, ".idx"}, {12'h000, idx}, {12'h000, x.idx});
      check({tag, ".wrap"}, {15'h0000, wrap}, {15'h0000, x.wrap});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] ei;
      // Reset and stay off without load
      cyc("rst0", 1, 0, 0, 0, 4'd0, 0, 4'd0, 0);
      cyc("rst1", 1, 0, 0, 0, 4'd0, 0, 4'd0, 0);
      for (int i = 0; i < 3; i++) cyc("idle_noload", 0, 1, 0, 0, 4'd0, 0, 4'd0, 0);

      // Direct load and hold
      cyc("dir_load5", 0, 1, 0, 1, 4'd5, 1, 4'd5, 0);
      for (int i = 0; i < 20; i++) cyc("dir_hold5", 0, 1, 0, 0, 4'd0, 1, 4'd5, 0);
      cyc("dir_load15", 0, 1, 0, 1, 4'd15, 1, 4'd15, 0);

      // Scan from 14: index advances every 4 edges, wrap on each step to 0
      cyc("scan_load14", 0, 1, 1, 1, 4'd14, 1, 4'd14, 0);
      for (int k = 1; k <= 75; k++) begin
         ei = 4'((14 + k / 4) % 16);
         cyc("scan_run", 0, 1, 1, 0, 4'd0, 1, ei, (k % 4 == 0) && (ei == 4'd0));
      end

      // Load on the dwell-expiry edge: load wins, dwell restarts
      cyc("coll_load3", 0, 1, 1, 1, 4'd3, 1, 4'd3, 0);
      for (int i = 0; i < 3; i++) cyc("coll_hold3", 0, 1, 1, 0, 4'd0, 1, 4'd3, 0);
      cyc("coll_step4", 0, 1, 1, 0, 4'd0, 1, 4'd4, 0);
      // Mode back to direct mid-dwell freezes index
      cyc("freeze", 0, 1, 0, 0, 4'd0, 1, 4'd4, 0);
      for (int i = 0; i < 6; i++) cyc("freeze_hold", 0, 1, 0, 0, 4'd0, 1, 4'd4, 0);
      // Direct -> scan without load resumes from current index, fresh dwell
      cyc("resume", 0, 1, 1, 0, 4'd0, 1, 4'd4, 0);
      for (int i = 0; i < 3; i++) cyc("resume_hold", 0, 1, 1, 0, 4'd0, 1, 4'd4, 0);
      cyc("resume_step", 0, 1, 1, 0, 4'd0, 1, 4'd5, 0);
      // Load to zero never wraps
      cyc("load0_nowrap", 0, 1, 1, 1, 4'd0, 1, 4'd0, 0);

      // Enable drop mid-scan: off, index held, no restart without load
      cyc("scan_load14b", 0, 1, 1, 1, 4'd14, 1, 4'd14, 0);
      cyc("scan14b", 0, 1, 1, 0, 4'd0, 1, 4'd14, 0);
      cyc("en_drop", 0, 0, 1, 0, 4'd0, 0, 4'd14, 0);
      cyc("en_low", 0, 0, 1, 1, 4'd3, 0, 4'd14, 0);
      cyc("en_back0", 0, 1, 1, 0, 4'd0, 0, 4'd14, 0);
      cyc("en_back1", 0, 1, 1, 0, 4'd0, 0, 4'd14, 0);

      // Reset mid-scan
      cyc("scan_load9", 0, 1, 1, 1, 4'd9, 1, 4'd9, 0);
      cyc("scan9", 0, 1, 1, 0, 4'd0, 1, 4'd9, 0);
      cyc("rst_mid", 1, 1, 1, 0, 4'd0, 0, 4'd0, 0);
      cyc("post_rst", 0, 1, 1, 0, 4'd0, 0, 4'd0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
